// File: rtl/ram_bist_ctrl_if.sv
// Controller-to-RAM access port: write enable, address, write data, and registered read data.
// The BIST controller drives the master side; the memory (or its wrapper) is the slave.
interface ram_bist_ctrl_if #(
  parameter int AWID = 8,
  parameter int DWID = 16
);
  logic            ram_we;
  logic [AWID-1:0] ram_addr;
  logic [DWID-1:0] ram_din;
  logic [DWID-1:0] ram_dout;

  modport master (output ram_we, ram_addr, ram_din, input ram_dout);
  modport slave  (input ram_we, ram_addr, ram_din, output ram_dout);
endinterface

// File: rtl/ram_bist_ctrl.sv
// RAM BIST initiator: writes pat(a)=seed+a to every word, reads back, compares; optional RAM_BIST_INVERT_PASS_EN adds a ~pat pass.
// Latency: busy for 2*DEPTH+1 cycles (4*DEPTH+2 with the inverted pass), then a one-cycle done pulse.
// Backpressure: none; the RAM takes one access per cycle and start is ignored unless the controller is idle.
module ram_bist_ctrl #(
  parameter int DEPTH = 256,
  parameter int AWID  = 8,
  parameter int DWID  = 16,
  parameter int ERRW  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DWID-1:0]   seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERRW-1:0]   err_cnt,
  output logic [AWID-1:0]   fail_addr,
  ram_bist_ctrl_if.master   ram
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [AWID-1:0] LAST_ADDR = AWID'(DEPTH - 1);
  localparam logic [ERRW-1:0] ERR_MAX   = '1;

  state_t          state_q, state_d;
  logic [AWID-1:0] addr_q, addr_d;
  logic [DWID-1:0] seed_q;
  logic            accept;
  logic [DWID-1:0] pat;

  logic            rd_vld_q;
  logic [DWID-1:0] exp_q;
  logic [AWID-1:0] exp_addr_q;
  logic            mism;
  logic [ERRW-1:0] err_q, err_d;
  logic [AWID-1:0] fail_q;
  logic            pass_q;

`ifdef RAM_BIST_INVERT_PASS_EN
  logic inv_q, inv_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inv_q <= 1'b0;
    else        inv_q <= inv_d;
  end

  assign pat = inv_q ? ~(seed_q + DWID'(addr_q)) : (seed_q + DWID'(addr_q));
`else
  assign pat = seed_q + DWID'(addr_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    accept  = 1'b0;
`ifdef RAM_BIST_INVERT_PASS_EN
    inv_d   = inv_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          addr_d  = '0;
          state_d = S_WRITE;
`ifdef RAM_BIST_INVERT_PASS_EN
          inv_d   = 1'b0;
`endif
        end
      end
      S_WRITE: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_READ;
        end else begin
          addr_d  = addr_q + AWID'(1);
        end
      end
      S_READ: begin
        // Counter parks at 0 so upper addresses are never presented to the RAM.
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d  = addr_q + AWID'(1);
        end
      end
      S_DRAIN: begin
`ifdef RAM_BIST_INVERT_PASS_EN
        if (!inv_q) begin
          inv_d   = 1'b1;
          state_d = S_WRITE;
        end else begin
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data returns one cycle after the address, so expected data and address trail by one stage.
  assign mism  = rd_vld_q && (ram.ram_dout != exp_q);
  assign err_d = (mism && (err_q != ERR_MAX)) ? err_q + ERRW'(1) : err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q     <= '0;
      rd_vld_q   <= 1'b0;
      exp_q      <= '0;
      exp_addr_q <= '0;
      err_q      <= '0;
      fail_q     <= '0;
      pass_q     <= 1'b0;
    end else begin
      rd_vld_q   <= (state_q == S_READ);
      exp_q      <= pat;
      exp_addr_q <= addr_q;
      if (accept) begin
        seed_q <= seed;
        err_q  <= '0;
        fail_q <= '0;
        pass_q <= 1'b0;
      end else begin
        err_q <= err_d;
        // err_q never returns to zero once counting, so zero marks the first mismatch.
        if (mism && (err_q == '0)) fail_q <= exp_addr_q;
        if ((state_q == S_DRAIN) && (state_d == S_DONE)) pass_q <= (err_d == '0);
      end
    end
  end

  assign busy      = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_q;
  assign fail_addr = fail_q;

  assign ram.ram_we   = (state_q == S_WRITE);
  assign ram.ram_addr = addr_q;
  assign ram.ram_din  = (state_q == S_WRITE) ? pat : '0;

endmodule
